// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for bin_to_bcd_seq.
// Build option: BCD_DIV3_FLAG_EN enables the divisible-by-3 result flag.
package bcd_pkg;

  localparam int BIN_W     = 14;
  localparam int N_DIGITS  = 4;
  localparam int MAX_VAL   = 9999;
  localparam int SHIFT_CNT = 14;
  localparam int CNT_W     = 4;
  localparam int BCD_W     = 4 * N_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit sum of a packed 4-digit BCD word, reduced mod 3.
  function automatic logic div3_of(input logic [BCD_W-1:0] bcd);
    logic [5:0] s;
    s = {2'b00, bcd[3:0]}  + {2'b00, bcd[7:4]}
      + {2'b00, bcd[11:8]} + {2'b00, bcd[15:12]};
    return (s % 6'd3) == 6'd0;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is >= 5.
// Purely combinational; one instance per result digit.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  // Pre-shift correction so the digit carries correctly after doubling.
  always_comb begin
    q_o = d_i;
    if (d_i >= 4'd5) q_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble).
// Build option: BCD_DIV3_FLAG_EN adds a registered divisible-by-3 flag.
import bcd_pkg::*;

module bin_to_bcd_seq (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] D,
  output logic             err,
  output logic             div3
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] opr_q, opr_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] d_q, d_d;
  logic             err_q, err_d;
  logic [BCD_W-1:0] adj;
  logic             over;
  logic             last;

  assign over = bin > MAX_BIN;
  // Shifting finished; this cycle moves the accumulator into the result.
  assign last = (state_q == SHIFT) && (cnt_q == '0);

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d_i (acc_q[4*g +: 4]),
      .q_o (adj[4*g +: 4])
    );
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    acc_d   = acc_q;
    d_d     = d_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opr_d   = over ? MAX_BIN : bin;
          err_d   = over;
          acc_d   = '0;
          cnt_d   = CNT_W'(SHIFT_CNT);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = BCD_W'({adj, opr_q[BIN_W-1]});
          opr_d = opr_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          d_d     = acc_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opr_q   <= '0;
      acc_q   <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign D         = d_q;
  assign err       = err_q;

`ifdef BCD_DIV3_FLAG_EN
  logic div3_q;

  // Flag captured together with the result on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div3_q <= 1'b0;
    else if (last) div3_q <= div3_of(acc_q);
  end

  assign div3 = div3_q;
`else
  logic unused_last;
  assign unused_last = last;
  assign div3 = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed operands, queued
// expectations, monitor compares on every output handshake.
module tb_bin_to_bcd_seq;

`ifdef BCD_DIV3_FLAG_EN
  localparam bit DIV3_EN = 1'b1;
`else
  localparam bit DIV3_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] d;
    logic        err;
    logic        d3;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        err;
  logic        div3;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bin_to_bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .err       (err),
    .div3      (div3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a result is consumed when out_valid and out_ready meet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(D), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("D", 32'(D), 32'(e.d));
        chk("err", 32'(err), 32'(e.err));
        chk("div3", 32'(div3), 32'(e.d3));
      end
    end
  end

  task automatic send(input logic [13:0] b, input logic [15:0] ed,
                      input logic ee, input logic e3);
    exp_t e;
    int   n;
    bit   ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    chk("in_ready_wait", 32'(ok), 32'd1);
    in_valid = 1'b1;
    bin      = b;
    e.d      = ed;
    e.err    = ee;
    e.d3     = e3 & DIV3_EN;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("accepted", 32'(in_ready), 32'd0);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 40) begin
      @(posedge clk);
      n++;
      #1 ok = out_valid;
    end
    chk("latency", 32'(n), 32'd15);
  endtask

  task automatic drain;
    bit busy;
    busy = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk);
      #1 busy = out_valid;
    end
    chk("left_done", 32'(out_valid), 32'd0);
  endtask

  task automatic run(input logic [13:0] b, input logic [15:0] ed,
                     input logic ee, input logic e3);
    send(b, ed, ee, e3);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    bin       = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_div3", 32'(div3), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(14'd0,     16'h0000, 1'b0, 1'b1);
    run(14'd9999,  16'h9999, 1'b0, 1'b1);
    run(14'd1234,  16'h1234, 1'b0, 1'b0);
    run(14'd12000, 16'h9999, 1'b1, 1'b1);
    run(14'd3333,  16'h3333, 1'b0, 1'b1);
    run(14'd5,     16'h0005, 1'b0, 1'b0);
    run(14'd10000, 16'h9999, 1'b1, 1'b1);

    // Reset in the 7th shift cycle discards the conversion.
    @(negedge clk);
    in_valid = 1'b1;
    bin      = 14'd8314;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_D", 32'(D), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_div3", 32'(div3), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("no_valid_after_rst", 32'(seen), 32'd0);

    run(14'd2214, 16'h2214, 1'b0, 1'b1);

    // Consumer stall: DONE holds, new operands are ignored.
    out_ready = 1'b0;
    send(14'd4321, 16'h4321, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      bin      = 14'd77;
      @(posedge clk);
      #1;
      chk("hold_D", 32'(D), 32'h4321);
      chk("hold_err", 32'(err), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    run(14'd9909,  16'h9909, 1'b0, 1'b1);
    run(14'd16383, 16'h9999, 1'b1, 1'b1);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
